// File: rtl/mkio_pkg.sv
// Shared types for the MKIO remote-terminal controller.
// Command word layout, state encoding and broadcast address.
package mkio_pkg;

    localparam int MKIO_WORD_W = 16;
    localparam logic [4:0] BCAST_ADDR = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_ACTIVE,
        ST_ABORT
    } state_t;

    // Field order fixes the bit positions: addr[15:11] tr[10] sa[9:5] wc[4:0]
    typedef struct packed {
        logic [4:0] addr;
        logic       tr;
        logic [4:0] sa;
        logic [4:0] wc;
    } cmd_t;

endpackage

// File: rtl/mkio_if.sv
// Word receiver / transmitter link seen by the RT controller.
// master = Manchester PHY side, slave = controller side.
interface mkio_if;
    import mkio_pkg::*;

    logic                   rx_done;
    logic [MKIO_WORD_W-1:0] rx_data;
    logic                   rx_cd;
    logic                   p_error;
    logic [MKIO_WORD_W-1:0] tx_data;
    logic                   tx_cd;
    logic                   tx_ready;

    modport master (
        output rx_done, rx_data, rx_cd, p_error,
        input  tx_data, tx_cd, tx_ready
    );

    modport slave (
        input  rx_done, rx_data, rx_cd, p_error,
        output tx_data, tx_cd, tx_ready
    );

endinterface

// File: rtl/mkio_cmd_decode.sv
// Combinational command-word check: accept flag, device index, broadcast.
// Receive-only: T/R=1 and unserved subaddresses are refused.
module mkio_cmd_decode
    import mkio_pkg::*;
#(
    parameter logic [4:0] RT_ADDRESS = 5'd1,
    parameter int         NUM_DEV    = 4,
    parameter logic [4:0] SA_BASE    = 5'd1,
    parameter int         IDX_W      = 2
) (
    input  logic [MKIO_WORD_W-1:0] word,
    input  logic                   cd,
    input  logic                   p_error,
    output logic                   accept,
    output logic [IDX_W-1:0]       dev_idx,
    output logic                   bcast
);

    cmd_t c;
    logic addr_ok;
    logic sa_ok;
    logic unused_wc;

    assign c         = cmd_t'(word);
    assign unused_wc = ^c.wc;
    assign bcast     = (c.addr == BCAST_ADDR);
    assign addr_ok   = bcast | (c.addr == RT_ADDRESS);
    assign sa_ok     = (c.sa >= SA_BASE) &&
                       ({1'b0, c.sa} < ({1'b0, SA_BASE} + 6'(NUM_DEV)));
    assign dev_idx   = IDX_W'(c.sa - SA_BASE);
    assign accept    = cd & ~p_error & addr_ok & ~c.tr & sa_ok;

endmodule

// File: rtl/mkio_rt_controller.sv
// MKIO remote-terminal message controller: command dispatch to the
// per-subaddress devices, response muxing, timeout and supersession.
module mkio_rt_controller
    import mkio_pkg::*;
#(
    parameter logic [4:0]  RT_ADDRESS = 5'd1,
    parameter int          NUM_DEV    = 4,
    parameter logic [4:0]  SA_BASE    = 5'd1,
    parameter logic [15:0] TIMEOUT    = 16'd2000
) (
    input  logic                           clk,
    input  logic                           reset,
    mkio_if.slave                          bus,
    output logic [NUM_DEV-1:0]             dev_start,
    output logic [NUM_DEV-1:0]             dev_reset,
    input  logic [NUM_DEV-1:0]             dev_busy,
    input  logic [MKIO_WORD_W*NUM_DEV-1:0] dev_tx_data,
    input  logic [NUM_DEV-1:0]             dev_tx_cd,
    input  logic [NUM_DEV-1:0]             dev_tx_ready,
    output logic                           msg_done,
    output logic                           msg_timeout,
    output logic                           cmd_reject
);

    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    state_t                 state, nxt;
    logic [IDX_W-1:0]       sel, sel_n, pend_sel, ps_n;
    logic                   bcast, bcast_n, pend_bcast, pb_n;
    logic                   pend_valid, pv_n;
    logic                   seen_busy, seen_n;
    logic [15:0]            timer, timer_n;
    logic [NUM_DEV-1:0]     start_n, dreset_n;
    logic                   done_n, tmo_n, rej_n;
    logic                   new_cmd, acc, d_bc;
    logic [IDX_W-1:0]       d_idx;
    logic [MKIO_WORD_W-1:0] txd_q;
    logic                   txc_q, txr_q;

    mkio_cmd_decode #(
        .RT_ADDRESS (RT_ADDRESS),
        .NUM_DEV    (NUM_DEV),
        .SA_BASE    (SA_BASE),
        .IDX_W      (IDX_W)
    ) u_dec (
        .word    (bus.rx_data),
        .cd      (bus.rx_cd),
        .p_error (bus.p_error),
        .accept  (acc),
        .dev_idx (d_idx),
        .bcast   (d_bc)
    );

    assign new_cmd = bus.rx_done & bus.rx_cd;

    always_comb begin
        nxt      = state;
        sel_n    = sel;
        bcast_n  = bcast;
        timer_n  = timer;
        seen_n   = seen_busy;
        pv_n     = pend_valid;
        ps_n     = pend_sel;
        pb_n     = pend_bcast;
        start_n  = '0;
        dreset_n = '0;
        done_n   = 1'b0;
        tmo_n    = 1'b0;
        rej_n    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (new_cmd && acc) begin
                    sel_n   = d_idx;
                    bcast_n = d_bc;
                    nxt     = ST_START;
                end else if (new_cmd) begin
                    rej_n = 1'b1;
                end
            end
            ST_START: begin
                start_n[sel] = 1'b1;
                timer_n      = '0;
                seen_n       = 1'b0;
                nxt          = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (dev_busy[sel])
                    seen_n = 1'b1;
                if (bus.rx_done || dev_tx_ready[sel])
                    timer_n = '0;
                else if (timer != 16'hFFFF)
                    timer_n = timer + 16'd1;
                // New command outranks timeout, which outranks completion
                if (new_cmd) begin
                    pv_n          = acc;
                    ps_n          = d_idx;
                    pb_n          = d_bc;
                    rej_n         = ~acc;
                    dreset_n[sel] = 1'b1;
                    nxt           = ST_ABORT;
                end else if (timer == TIMEOUT) begin
                    pv_n          = 1'b0;
                    tmo_n         = 1'b1;
                    dreset_n[sel] = 1'b1;
                    nxt           = ST_ABORT;
                end else if (!dev_busy[sel] && seen_busy) begin
                    done_n = 1'b1;
                    nxt    = ST_IDLE;
                end
            end
            ST_ABORT: begin
                // Pending command restarts straight away so its start
                // pulse follows the abort pulse by one clock
                if (pend_valid) begin
                    sel_n             = pend_sel;
                    bcast_n           = pend_bcast;
                    start_n[pend_sel] = 1'b1;
                    timer_n           = '0;
                    seen_n            = 1'b0;
                    pv_n              = 1'b0;
                    nxt               = ST_ACTIVE;
                end else begin
                    nxt = ST_IDLE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            sel         <= '0;
            bcast       <= 1'b0;
            timer       <= '0;
            seen_busy   <= 1'b0;
            pend_valid  <= 1'b0;
            pend_sel    <= '0;
            pend_bcast  <= 1'b0;
            dev_start   <= '0;
            dev_reset   <= '0;
            msg_done    <= 1'b0;
            msg_timeout <= 1'b0;
            cmd_reject  <= 1'b0;
            txd_q       <= '0;
            txc_q       <= 1'b0;
            txr_q       <= 1'b0;
        end else begin
            state       <= nxt;
            sel         <= sel_n;
            bcast       <= bcast_n;
            timer       <= timer_n;
            seen_busy   <= seen_n;
            pend_valid  <= pv_n;
            pend_sel    <= ps_n;
            pend_bcast  <= pb_n;
            dev_start   <= start_n;
            dev_reset   <= dreset_n;
            msg_done    <= done_n;
            msg_timeout <= tmo_n;
            cmd_reject  <= rej_n;
            if (state == ST_ACTIVE && nxt == ST_ACTIVE) begin
                txd_q <= dev_tx_data[{sel, 4'b0000} +: MKIO_WORD_W];
                txc_q <= dev_tx_cd[sel];
                txr_q <= dev_tx_ready[sel] & ~bcast;
            end else begin
                txd_q <= '0;
                txc_q <= 1'b0;
                txr_q <= 1'b0;
            end
        end
    end

    assign bus.tx_data  = txd_q;
    assign bus.tx_cd    = txc_q;
    assign bus.tx_ready = txr_q;

endmodule

// File: tb/tb_mkio_rt_controller.sv
// Directed plus randomized bench for mkio_rt_controller with a
// rule-level command acceptance model.
module tb_mkio_rt_controller;

    localparam int          TMO     = 200;
    localparam int          NDEV    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  dev_start, dev_reset;
    logic [3:0]  dev_busy = '0;
    logic [63:0] dev_tx_data = '0;
    logic [3:0]  dev_tx_cd = '0;
    logic [3:0]  dev_tx_ready = '0;
    logic        msg_done, msg_timeout, cmd_reject;
    int          tests = 0;
    int          fails = 0;

    mkio_if bus();

    mkio_rt_controller #(
        .RT_ADDRESS (5'd1),
        .NUM_DEV    (NDEV),
        .SA_BASE    (5'd1),
        .TIMEOUT    (16'(TMO))
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dev_start    (dev_start),
        .dev_reset    (dev_reset),
        .dev_busy     (dev_busy),
        .dev_tx_data  (dev_tx_data),
        .dev_tx_cd    (dev_tx_cd),
        .dev_tx_ready (dev_tx_ready),
        .msg_done     (msg_done),
        .msg_timeout  (msg_timeout),
        .cmd_reject   (cmd_reject)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] w, input logic cd,
                        input logic pe);
        bus.rx_data = w;
        bus.rx_cd   = cd;
        bus.p_error = pe;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.p_error = 1'b0;
    endtask

    // Acceptance from the word fields: {accept, reject, one-hot start}
    function automatic logic [5:0] model(input logic [15:0] w,
                                         input logic cd, input logic pe);
        int addr, tr, sa;
        logic ok;
        addr = int'(w) / 2048;
        tr   = (int'(w) / 1024) % 2;
        sa   = (int'(w) / 32) % 32;
        ok   = cd && !pe && (addr == 1 || addr == 31) && tr == 0 &&
               sa >= 1 && sa <= NDEV;
        return {ok, cd && !ok, ok ? 4'(1 << (sa - 1)) : 4'd0};
    endfunction

    task automatic outs_zero(input string tag);
        chk(tag, {dev_start, dev_reset, msg_done, msg_timeout, cmd_reject,
                  bus.tx_ready, bus.tx_cd, bus.tx_data}, 0);
    endtask

    initial begin
        logic [5:0]  m;
        logic [15:0] w;
        logic        cd, pe;
        int          n, addr_sel;
        logic [15:0] rej_w[4];
        logic        rej_cd[4];
        logic        rej_pe[4];

        bus.rx_done = 1'b0;
        bus.rx_data = '0;
        bus.rx_cd   = 1'b0;
        bus.p_error = 1'b0;
        tick();
        tick();
        outs_zero("reset_outputs");
        reset = 1'b1;
        tick();

        // Receive command to SA3, three data words, status, completion
        send(16'h0863, 1'b1, 1'b0);
        chk("sa3_start_early", dev_start, 0);
        chk("sa3_no_reject", cmd_reject, 0);
        tick();
        chk("sa3_start", dev_start, 4'b0100);
        dev_busy[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(16'h1000 + 16'(i), 1'b0, 1'b0);
            chk("sa3_data_quiet", {dev_start, cmd_reject, msg_done}, 0);
        end
        dev_tx_data[47:32] = 16'h0800;
        dev_tx_cd[2]       = 1'b1;
        dev_tx_ready[2]    = 1'b1;
        tick();
        chk("sa3_tx_data", bus.tx_data, 16'h0800);
        chk("sa3_tx_flags", {bus.tx_cd, bus.tx_ready}, 2'b11);
        dev_tx_ready = '0;
        dev_tx_cd    = '0;
        dev_busy     = '0;
        tick();
        chk("sa3_done", msg_done, 1);
        chk("sa3_tx_idle", bus.tx_ready, 0);
        tick();
        chk("sa3_done_pulse", msg_done, 0);

        // Broadcast to SA2: device status must never reach the transmitter
        send(16'hF841, 1'b1, 1'b0);
        tick();
        chk("bc_start", dev_start, 4'b0010);
        dev_busy[1] = 1'b1;
        send(16'h5555, 1'b0, 1'b0);
        dev_tx_data[31:16] = 16'hF800;
        dev_tx_cd[1]       = 1'b1;
        dev_tx_ready[1]    = 1'b1;
        tick();
        chk("bc_tx_ready", bus.tx_ready, 0);
        dev_tx_ready = '0;
        dev_tx_cd    = '0;
        dev_busy     = '0;
        tick();
        chk("bc_done", msg_done, 1);
        tick();

        // Commands that must be refused, and a data word in IDLE
        rej_w  = '{16'h1022, 16'h0C22, 16'h0822, 16'h0822};
        rej_cd = '{1'b1, 1'b1, 1'b1, 1'b0};
        rej_pe = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            m = model(rej_w[i], rej_cd[i], rej_pe[i]);
            send(rej_w[i], rej_cd[i], rej_pe[i]);
            chk("rej_pulse", cmd_reject, m[4]);
            tick();
            chk("rej_dev_idle", {dev_start, dev_reset, cmd_reject}, 0);
        end

        // Timeout: timer counts TMO clocks after the last word, pulse registered
        send(16'h0822, 1'b1, 1'b0);
        tick();
        chk("tmo_start", dev_start, 4'b0001);
        dev_busy[0] = 1'b1;
        send(16'h0001, 1'b0, 1'b0);
        n = 0;
        while (!msg_timeout && !msg_done && n < 2 * TMO) begin
            tick();
            n++;
        end
        chk("tmo_latency", n, TMO + 1);
        chk("tmo_pulse", msg_timeout, 1);
        chk("tmo_dev_reset", dev_reset, 4'b0001);
        dev_busy = '0;
        tick();
        chk("tmo_pulses_end", {dev_reset, msg_timeout}, 0);
        tick();

        // Supersession: new command during an active message
        send(16'h0822, 1'b1, 1'b0);
        tick();
        dev_busy[0] = 1'b1;
        send(16'h0002, 1'b0, 1'b0);
        send(16'h0863, 1'b1, 1'b0);
        chk("sup_reset", dev_reset, 4'b0001);
        chk("sup_no_start_yet", dev_start, 0);
        dev_busy = '0;
        tick();
        chk("sup_start", dev_start, 4'b0100);
        chk("sup_reset_end", dev_reset, 0);
        dev_busy[2] = 1'b1;
        dev_tx_data[47:32] = 16'h0801;
        dev_tx_ready[2]    = 1'b1;
        tick();
        chk("sup_tx", {bus.tx_ready, bus.tx_data}, {1'b1, 16'h0801});
        dev_tx_ready = '0;
        dev_busy     = '0;
        tick();
        chk("sup_done", msg_done, 1);
        tick();

        // Reset in the middle of a message
        send(16'h0822, 1'b1, 1'b0);
        tick();
        dev_busy[0]        = 1'b1;
        dev_tx_data[15:0]  = 16'h0802;
        dev_tx_cd[0]       = 1'b1;
        dev_tx_ready[0]    = 1'b1;
        tick();
        chk("rst_pre_tx", bus.tx_ready, 1);
        reset = 1'b0;
        #1;
        outs_zero("rst_async_outputs");
        dev_busy     = '0;
        dev_tx_ready = '0;
        dev_tx_cd    = '0;
        tick();
        reset = 1'b1;
        tick();
        send(16'h0822, 1'b1, 1'b0);
        tick();
        chk("rst_after_start", dev_start, 4'b0001);
        dev_busy[0] = 1'b1;
        tick();
        dev_busy = '0;
        tick();
        chk("rst_after_done", msg_done, 1);
        tick();

        // Randomized command words against the acceptance model
        for (int k = 0; k < 40; k++) begin
            addr_sel = int'($urandom_range(0, 3));
            w[15:11] = (addr_sel == 0) ? 5'd1 : (addr_sel == 1) ? 5'd31
                                               : 5'($urandom_range(0, 31));
            w[10]    = ($urandom_range(0, 3) == 0);
            w[9:5]   = 5'($urandom_range(0, 7));
            w[4:0]   = 5'($urandom_range(0, 31));
            cd       = ($urandom_range(0, 7) != 0);
            pe       = ($urandom_range(0, 7) == 0);
            m        = model(w, cd, pe);
            send(w, cd, pe);
            chk("rnd_reject", cmd_reject, m[4]);
            tick();
            chk("rnd_start", dev_start, m[3:0]);
            if (m[5]) begin
                dev_busy = m[3:0];
                tick();
                dev_busy = '0;
                tick();
                chk("rnd_done", msg_done, 1);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
